// File: rtl/keypad_hex_scanner.sv
// rtl/keypad_hex_scanner.sv - 4x4 active-low hex keypad scanner with press/release debounce
// Optional 16-bit digit entry register is built when KEYPAD_ENTRY_EN is defined.
module keypad_hex_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [7:0] entry_msb,
  output logic [7:0] entry_lsb
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state, state_n;
  logic [3:0]    row_m, row_s;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    col_idx, col_idx_n;
  logic [1:0]    r_idx, r_idx_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          any_low;
  logic [1:0]    low_row;
  logic          accept;
  logic [3:0]    code_n;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [15:0] row_codes;
    case (r)
      2'd0:    row_codes = 16'h123A;
      2'd1:    row_codes = 16'h456B;
      2'd2:    row_codes = 16'h789C;
      default: row_codes = 16'hE0FD;
    endcase
    case (c)
      2'd0:    return row_codes[15:12];
      2'd1:    return row_codes[11:8];
      2'd2:    return row_codes[7:4];
      default: return row_codes[3:0];
    endcase
  endfunction

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign tick    = (presc == PRESC_MAX);
  assign any_low = (row_s != 4'hF);
  assign cnt_inc = cnt + 1'b1;
  assign col_out = ~(4'b0001 << col_idx);

  // Lowest-numbered low row wins when several keys share the driven column
  always_comb begin
    low_row = 2'd3;
    if (!row_s[0])      low_row = 2'd0;
    else if (!row_s[1]) low_row = 2'd1;
    else if (!row_s[2]) low_row = 2'd2;
  end

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    r_idx_n   = r_idx;
    cnt_n     = cnt;
    accept    = 1'b0;
    code_n    = key_map(r_idx, col_idx);
    if (tick) begin
      case (state)
        SCAN: begin
          if (!any_low) begin
            col_idx_n = col_idx + 1'b1;
          end else begin
            r_idx_n = low_row;
            cnt_n   = CW'(1);
            code_n  = key_map(low_row, col_idx);
            if (DEBOUNCE_TICKS == 1) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (any_low && (low_row == r_idx)) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end
          end else begin
            state_n   = SCAN;
            col_idx_n = col_idx + 1'b1;
          end
        end
        PRESSED: begin
          if (!any_low) begin
            cnt_n   = CW'(1);
            state_n = (DEBOUNCE_TICKS == 1) ? SCAN : RELEASE;
          end
        end
        RELEASE: begin
          // Column stays parked on the released key; any low row is chatter
          if (!any_low) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) state_n = SCAN;
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      r_idx     <= 2'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      r_idx     <= r_idx_n;
      cnt       <= cnt_n;
      key_valid <= accept;
      if (accept) key_code <= code_n;
      key_held  <= (state_n == PRESSED) || (state_n == RELEASE);
    end
  end

`ifdef KEYPAD_ENTRY_EN
  logic [15:0] entry;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)       entry <= 16'h0000;
    else if (accept) entry <= {entry[11:0], code_n};
  end

  assign entry_msb = entry[15:8];
  assign entry_lsb = entry[7:0];
`else
  assign entry_msb = 8'h00;
  assign entry_lsb = 8'h00;
`endif

endmodule
